// File: rtl/alpha_mls_iter.sv
// alpha_mls_iter: masked, iterative multiply-by-alpha^n engine over GF(2^W).
//
// The field is defined by the feedback polynomial x^W + x^TAP + 1. Each request
// applies n alpha steps to every one of the D shares. The operation is linear,
// so each share is processed on its own and shares are never mixed.
//
// Handshake and timing:
//   - A request is accepted in IDLE on in_valid & in_ready.
//   - Each RUN cycle applies up to STEP steps.
//   - The result is held in DONE until out_valid & out_ready.
//
// Optional feature, selected by the macro ALPHA_MLS_INV_EN:
//   - Defined: mode_in = 1 selects divide-by-alpha, and the inverse step
//     datapath is built.
//   - Undefined: mode_in is ignored and only the forward step exists.
module alpha_mls_iter #(
    parameter int W     = 32,  // field width, >= TAP+2
    parameter int TAP   = 8,   // low feedback tap, 1 <= TAP < W-1
    parameter int D     = 2,   // number of shares
    parameter int STEP  = 1,   // alpha steps per RUN cycle, 1..8
    parameter int CNT_W = 8    // width of the step count
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D*W-1:0]   x_in,
    input  logic [CNT_W-1:0] n_in,
    input  logic             mode_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D*W-1:0]   x_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    state_t           state_q, state_d;
    logic [D*W-1:0]   x_q, x_d;      // working register, also drives x_out
    logic [CNT_W-1:0] rem_q, rem_d;  // steps still to apply; only ever counts down
    logic [CNT_W-1:0] k_sel;         // steps applied in the current RUN cycle
    logic [D*W-1:0]   step_res;      // working register advanced by k_sel steps
    logic             accept;

`ifdef ALPHA_MLS_INV_EN
    logic mode_q, mode_d;
`else
    // Without the inverse datapath the direction input has no function.
    logic mode_unused;
    assign mode_unused = mode_in;
`endif

    // Single multiply by alpha: shift up, then fold the dropped MSB back
    // into bit 0 and bit TAP.
    function automatic logic [W-1:0] alpha_fwd(input logic [W-1:0] x);
        logic [W-1:0] fb;
        fb      = '0;
        fb[0]   = x[W-1];
        fb[TAP] = x[W-1];
        return {x[W-2:0], 1'b0} ^ fb;
    endfunction

    // Apply k forward steps (k <= STEP) as an unrolled chain of conditional stages.
    function automatic logic [W-1:0] alpha_fwd_k(input logic [W-1:0] x,
                                                 input logic [CNT_W-1:0] k);
        logic [W-1:0] y;
        y = x;
        for (int s = 0; s < STEP; s++) begin
            if (CNT_W'(s) < k) begin
                y = alpha_fwd(y);
            end
        end
        return y;
    endfunction

`ifdef ALPHA_MLS_INV_EN
    // Single divide by alpha. Bit 0 of a forward result always equals the
    // MSB that was folded back, so bit 0 identifies the feedback to undo.
    function automatic logic [W-1:0] alpha_inv(input logic [W-1:0] x);
        logic [W-1:0] fb;
        logic [W-1:0] t;
        fb      = '0;
        fb[0]   = x[0];
        fb[TAP] = x[0];
        t       = x ^ fb;
        return {x[0], t[W-1:1]};
    endfunction

    // Apply k inverse steps (k <= STEP).
    function automatic logic [W-1:0] alpha_inv_k(input logic [W-1:0] x,
                                                 input logic [CNT_W-1:0] k);
        logic [W-1:0] y;
        y = x;
        for (int s = 0; s < STEP; s++) begin
            if (CNT_W'(s) < k) begin
                y = alpha_inv(y);
            end
        end
        return y;
    endfunction
`endif

    // Never overshoot the remaining count, so the counter cannot wrap.
    assign k_sel = (rem_q > STEP_C) ? STEP_C : rem_q;

    // Per-share step datapath. Shares are independent because the operation is linear.
    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_share
            logic [W-1:0] share_cur;
            assign share_cur = x_q[gi*W +: W];
`ifdef ALPHA_MLS_INV_EN
            assign step_res[gi*W +: W] = mode_q ? alpha_inv_k(share_cur, k_sel)
                                                : alpha_fwd_k(share_cur, k_sel);
`else
            assign step_res[gi*W +: W] = alpha_fwd_k(share_cur, k_sel);
`endif
        end
    endgenerate

    assign accept = in_valid & in_ready;

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            rem_q   <= '0;
`ifdef ALPHA_MLS_INV_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
`ifdef ALPHA_MLS_INV_EN
            mode_q  <= mode_d;
`endif
        end
    end

    // Next-state and datapath update: load in IDLE, step in RUN, wait in DONE.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        rem_d   = rem_q;
`ifdef ALPHA_MLS_INV_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    x_d     = x_in;
                    rem_d   = n_in;
`ifdef ALPHA_MLS_INV_EN
                    mode_d  = mode_in;
`endif
                    state_d = (n_in == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                x_d   = step_res;
                rem_d = rem_q - k_sel;
                if (rem_q == k_sel) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Return to IDLE only; a new request is accepted on a later cycle.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state. in_ready is also forced low while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: in_ready  = nrst;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign x_out = x_q;

endmodule

// File: tb/tb_alpha_mls_iter.sv
// Bench for alpha_mls_iter. Instance u=0 uses STEP=1 and instance u=1 uses STEP=4.
// Expected values come from a polynomial-arithmetic model of GF(2^32).
module tb_alpha_mls_iter;

`ifdef ALPHA_MLS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam logic [32:0] POLY = 33'h1_0000_0101;  // x^32 + x^8 + 1

    logic        clk = 1'b0;
    logic        nrst;
    logic        iv   [2];
    logic        ir   [2];
    logic [63:0] xi   [2];
    logic [7:0]  ni   [2];
    logic        mi   [2];
    logic        ov   [2];
    logic        ordy [2];
    logic [63:0] xo   [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alpha_mls_iter #(.W(32), .TAP(8), .D(2), .STEP(1), .CNT_W(8)) dut (
        .clk(clk), .nrst(nrst), .in_valid(iv[0]), .in_ready(ir[0]),
        .x_in(xi[0]), .n_in(ni[0]), .mode_in(mi[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .x_out(xo[0])
    );

    alpha_mls_iter #(.W(32), .TAP(8), .D(2), .STEP(4), .CNT_W(8)) dut4 (
        .clk(clk), .nrst(nrst), .in_valid(iv[1]), .in_ready(ir[1]),
        .x_in(xi[1]), .n_in(ni[1]), .mode_in(mi[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .x_out(xo[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: multiplication/division by the polynomial x modulo POLY.
    function automatic logic [31:0] ref_share(input logic [31:0] x, input int n, input bit inv);
        logic [32:0] v;
        v = {1'b0, x};
        for (int i = 0; i < n; i++) begin
            if (!inv) begin
                v = v << 1;
                if (v[32]) v = v ^ POLY;
            end else begin
                if (v[0]) v = v ^ POLY;
                v = v >> 1;
            end
        end
        return v[31:0];
    endfunction

    function automatic logic [63:0] ref_val(input logic [63:0] x, input int n, input bit mode);
        bit inv;
        inv = mode & INV_EN;
        return {ref_share(x[63:32], n, inv), ref_share(x[31:0], n, inv)};
    endfunction

    function automatic int ref_lat(input int u, input int n);
        int st;
        st = (u == 0) ? 1 : 4;
        return 1 + (n + st - 1) / st;
    endfunction

    // One full request/response transaction, with hold cycles of back-pressure in DONE.
    task automatic txn(input int u, input logic [63:0] x, input int n, input bit mode,
                       input int hold, input logic [63:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        chk("in_ready_idle", {63'd0, ir[u]}, 64'd1);
        iv[u] = 1'b1;
        xi[u] = x;
        ni[u] = n[7:0];
        mi[u] = mode;
        @(posedge clk);
        #1;
        iv[u] = 1'b0;
        xi[u] = {$urandom, $urandom};
        ni[u] = 8'($urandom);
        lat = 1;
        while (!ov[u] && lat < 600) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("out_valid_seen", {63'd0, ov[u]}, 64'd1);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("result", xo[u], exp);
        for (int h = 0; h < hold; h++) begin
            iv[u] = 1'b1;  // must be ignored while not in IDLE
            @(posedge clk);
            #1;
            chk("hold_valid", {63'd0, ov[u]}, 64'd1);
            chk("hold_data", xo[u], exp);
            chk("hold_in_ready", {63'd0, ir[u]}, 64'd0);
        end
        ordy[u] = 1'b1;
        @(posedge clk);
        #1;
        ordy[u] = 1'b0;
        iv[u]   = 1'b0;
        chk("release_valid", {63'd0, ov[u]}, 64'd0);
        chk("release_in_ready", {63'd0, ir[u]}, 64'd1);
        $display("txn u=%0d n=%0d mode=%0d x=%h -> %h lat=%0d", u, n, mode, x, xo[u], lat);
    endtask

    typedef struct {
        int          u;
        logic [63:0] x;
        int          n;
        bit          mode;
        int          hold;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [63:0] rx;
        logic [63:0] fw;
        logic [63:0] tmp;
        int          rn;
        bit          rm;

        // Directed vectors; shares are written {share1, share0}.
        tbl[0] = '{0, {32'h0000_0001, 32'h8000_0000}, 1, 1'b0, 10, {32'h0000_0002, 32'h0000_0101}, 2};
        tbl[1] = '{0, {32'h0000_0000, 32'h8000_0000}, 2, 1'b0, 0,  {32'h0000_0000, 32'h0000_0202}, 3};
        tbl[2] = '{0, {32'hDEAD_BEEF, 32'hDEAD_BEEF}, 0, 1'b0, 1,  {32'hDEAD_BEEF, 32'hDEAD_BEEF}, 1};
        tbl[3] = '{1, {32'h0000_0001, 32'h0000_0001}, 5, 1'b0, 0,  {32'h0000_0020, 32'h0000_0020}, 3};
        if (INV_EN)
            tbl[4] = '{0, {32'h0000_0101, 32'h0000_0101}, 1, 1'b1, 0, {32'h8000_0000, 32'h8000_0000}, 2};
        else
            tbl[4] = '{0, {32'h0000_0101, 32'h0000_0101}, 1, 1'b1, 0, {32'h0000_0202, 32'h0000_0202}, 2};
        tbl[5] = '{1, {32'h1234_5678, 32'h9ABC_DEF0}, 255, 1'b0, 0, 64'd0, 65};
        tbl[5].exp = ref_val(tbl[5].x, 255, 1'b0);
        tbl[6] = '{0, {32'hCAFE_F00D, 32'h0BAD_C0DE}, 255, 1'b0, 0, 64'd0, 256};
        tbl[6].exp = ref_val(tbl[6].x, 255, 1'b0);
        tbl[7] = '{1, {32'h0000_0001, 32'h8000_0000}, 4, 1'b0, 0,  {32'h0000_0010, 32'h0000_0808}, 2};
        tbl[8] = '{1, {32'h0000_0001, 32'h0000_0001}, 3, 1'b0, 2,  {32'h0000_0008, 32'h0000_0008}, 2};

        nrst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            iv[u]   = 1'b0;
            xi[u]   = '0;
            ni[u]   = '0;
            mi[u]   = 1'b0;
            ordy[u] = 1'b0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_out_valid", {63'd0, ov[u]}, 64'd0);
            chk("rst_x_out", xo[u], 64'd0);
            chk("rst_in_ready", {63'd0, ir[u]}, 64'd0);
        end
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("post_rst_in_ready0", {63'd0, ir[0]}, 64'd1);
        chk("post_rst_in_ready1", {63'd0, ir[1]}, 64'd1);

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            txn(tbl[i].u, tbl[i].x, tbl[i].n, tbl[i].mode, tbl[i].hold, tbl[i].exp, tbl[i].lat);
        end

        // Randomised requests against the model.
        for (int i = 0; i < 24; i++) begin
            rx = {$urandom, $urandom};
            rn = int'($urandom_range(0, 60));
            rm = 1'($urandom);
            txn(i % 2, rx, rn, rm, int'($urandom_range(0, 3)), ref_val(rx, rn, rm), ref_lat(i % 2, rn));
        end

        // Forward then inverse must round-trip.
        if (INV_EN) begin
            for (int u = 0; u < 2; u++) begin
                rx = {$urandom, $urandom};
                fw = ref_val(rx, 37, 1'b0);
                txn(u, rx, 37, 1'b0, 0, fw, ref_lat(u, 37));
                txn(u, fw, 37, 1'b1, 0, rx, ref_lat(u, 37));
            end
        end

        // Reset pulse in the middle of a long run.
        @(negedge clk);
        iv[0] = 1'b1;
        xi[0] = {32'h0000_0001, 32'h8000_0000};
        ni[0] = 8'd200;
        mi[0] = 1'b0;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        chk("midrun_busy", {63'd0, ir[0]}, 64'd0);
        nrst = 1'b0;
        #1;
        chk("abort_out_valid", {63'd0, ov[0]}, 64'd0);
        chk("abort_x_out", xo[0], 64'd0);
        chk("abort_in_ready", {63'd0, ir[0]}, 64'd0);
        @(posedge clk);
        #1;
        chk("abort_hold_x_out", xo[0], 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("abort_release_in_ready", {63'd0, ir[0]}, 64'd1);
        tmp = {32'h0000_0003, 32'h8000_0001};
        txn(0, tmp, 9, 1'b0, 0, ref_val(tmp, 9, 1'b0), 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
